// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// FSM state type and pipeline-register indices.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // Bit positions of the pipeline registers inside stage_valid.
  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the 5-stage pipeline datapath (master) and the hazard
// controller (slave). Counters are real only when PIPE_HAZARD_PERF_EN is set.
interface pipe_hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  import pipe_hazard_ctrl_pkg::*;

  // No valid/ready pair: every stage's content is qualified by stage_valid, and
  // enables/flushes driven here take effect on the next clock edge that has enable high.
  logic              enable;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [ADDR_W-1:0] ex_waddr;
  logic              mem_reg_write;
  logic [ADDR_W-1:0] mem_waddr;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_waddr;
  logic              redirect;

  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [3:0]        stage_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  hz_state_t         state;

  modport master (
    output enable, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
           ex_reg_write, ex_waddr, mem_reg_write, mem_waddr, wb_reg_write,
           wb_waddr, redirect,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, stage_valid, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  enable, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
           ex_reg_write, ex_waddr, mem_reg_write, mem_waddr, wb_reg_write,
           wb_waddr, redirect,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, stage_valid, stall_cnt, flush_cnt, state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// Operand forwarding select for one EX source register; EX_MEM beats MEM_WB
// and register 0 is never forwarded.
module fwd_sel_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              mem_wr,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              wb_wr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_waddr,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wr & mem_valid & (mem_waddr != '0) & (mem_waddr == src);
  assign wb_hit  = wb_wr & wb_valid & (wb_waddr != '0) & (wb_waddr == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stage valid tracking, load-use stall FSM, redirect flush and
// forwarding selects. Define PIPE_HAZARD_PERF_EN to build the stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_DEPTH     = 3,
  parameter int CNT_W           = 32
) (
  input logic              clk,
  input logic              arst_n,
  pipe_hazard_ctrl_if.slave bus
);

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [1:0] bub_cnt;
  logic [1:0] bub_cnt_nxt;
  logic [3:0] valid;
  logic       run;
  logic       hz;
  logic       redir;
  logic       stalling;
  logic       pc_en;
  logic       if_id_en;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       flush_ex_mem;

  // Outputs are forced quiet while reset is held, not just after it.
  assign run = arst_n & bus.enable;

  assign hz = valid[STG_IF_ID] & valid[STG_ID_EX] & bus.ex_mem_read & bus.ex_reg_write &
              (bus.ex_waddr != '0) &
              ((bus.ex_waddr == bus.id_rs) | (bus.id_uses_rt & (bus.ex_waddr == bus.id_rt)));

  assign redir    = bus.redirect & valid[STG_EX_MEM];
  assign stalling = (state == STALL) | hz;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else if (bus.enable) begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  // bub_cnt holds the bubbles still owed after the current STALL cycle.
  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    if (redir) begin
      state_nxt   = RUN;
      bub_cnt_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if (hz && (LOAD_USE_CYCLES > 1)) begin
            state_nxt   = STALL;
            bub_cnt_nxt = 2'(LOAD_USE_CYCLES - 2);
          end
        end
        STALL: begin
          if (bub_cnt == '0) state_nxt = RUN;
          else               bub_cnt_nxt = bub_cnt - 2'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (run) begin
      if (redir) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = (FLUSH_DEPTH >= 2);
        flush_ex_mem = (FLUSH_DEPTH >= 3);
      end else if (stalling) begin
        flush_id_ex  = 1'b1;
      end else begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid <= '0;
    end else if (bus.enable) begin
      valid[STG_IF_ID]  <= flush_if_id  ? 1'b0 : (if_id_en ? 1'b1 : valid[STG_IF_ID]);
      valid[STG_ID_EX]  <= flush_id_ex  ? 1'b0 : valid[STG_IF_ID];
      valid[STG_EX_MEM] <= flush_ex_mem ? 1'b0 : valid[STG_ID_EX];
      valid[STG_MEM_WB] <= valid[STG_EX_MEM];
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (bus.enable) begin
      if (stalling && !redir) stall_q <= stall_q + CNT_W'(1);
      if (redir)              flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

  fwd_sel_unit #(.ADDR_W(ADDR_W)) u_fwd_a (
    .src       (bus.ex_rs),
    .mem_wr    (bus.mem_reg_write),
    .mem_valid (valid[STG_EX_MEM]),
    .mem_waddr (bus.mem_waddr),
    .wb_wr     (bus.wb_reg_write),
    .wb_valid  (valid[STG_MEM_WB]),
    .wb_waddr  (bus.wb_waddr),
    .sel       (bus.fwd_a_sel)
  );

  fwd_sel_unit #(.ADDR_W(ADDR_W)) u_fwd_b (
    .src       (bus.ex_rt),
    .mem_wr    (bus.mem_reg_write),
    .mem_valid (valid[STG_EX_MEM]),
    .mem_waddr (bus.mem_waddr),
    .wb_wr     (bus.wb_reg_write),
    .wb_valid  (valid[STG_MEM_WB]),
    .wb_waddr  (bus.wb_waddr),
    .sel       (bus.fwd_b_sel)
  );

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = flush_if_id;
  assign bus.id_ex_flush  = flush_id_ex;
  assign bus.ex_mem_flush = flush_ex_mem;
  assign bus.stage_valid  = valid;
  assign bus.state        = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_USE_CYCLES 1 / 3) share one
// stimulus stream; a cycle model feeds per-instance expected queues.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int AW  = 5;
  localparam int CW1 = 16;
  localparam int CW3 = 4;
  localparam int W   = 45;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic          en;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rt;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic          ex_mem_read;
    logic          ex_reg_write;
    logic [AW-1:0] ex_waddr;
    logic          mem_reg_write;
    logic [AW-1:0] mem_waddr;
    logic          wb_reg_write;
    logic [AW-1:0] wb_waddr;
    logic          redirect;
  } stim_t;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW1)) bus1 ();
  pipe_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW3)) bus3 ();

  pipe_hazard_ctrl #(.ADDR_W(AW), .LOAD_USE_CYCLES(1), .FLUSH_DEPTH(3), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .bus(bus1.slave));
  pipe_hazard_ctrl #(.ADDR_W(AW), .LOAD_USE_CYCLES(3), .FLUSH_DEPTH(2), .CNT_W(CW3)) u_dut3 (
    .clk(clk), .arst_n(arst_n), .bus(bus3.slave));

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];

  // reference model state, index 0 -> u_dut1, 1 -> u_dut3
  logic [3:0]  m_valid[2];
  int          m_left[2];
  int unsigned m_stall[2];
  int unsigned m_flush[2];
  int          luc[2] = '{1, 3};
  int          fd[2]  = '{3, 2};
  int          cw[2]  = '{CW1, CW3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = '0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  function automatic logic hz_of(int k, stim_t s);
    logic [3:0] v;
    v = m_valid[k];
    return v[0] && v[1] && s.ex_mem_read && s.ex_reg_write && (s.ex_waddr != '0) &&
           ((s.ex_waddr == s.id_rs) || (s.id_uses_rt && (s.ex_waddr == s.id_rt)));
  endfunction

  function automatic logic [1:0] pick(logic [AW-1:0] r, stim_t s, logic [3:0] v);
    if (r != '0 && s.mem_reg_write && v[2] && s.mem_waddr == r) return FWD_MEM;
    if (r != '0 && s.wb_reg_write && v[3] && s.wb_waddr == r) return FWD_WB;
    return FWD_RF;
  endfunction

  // layout: pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, valid, stall, flush
  function automatic logic [W-1:0] model_out(int k, stim_t s);
    logic [3:0]  v;
    logic        run, red, stl, pc;
    logic [2:0]  fl;
    logic [15:0] sc, fc;
    int unsigned mask;
    v    = m_valid[k];
    run  = arst_n && s.en;
    red  = s.redirect && v[2];
    stl  = (m_left[k] > 0) || hz_of(k, s);
    pc   = 1'b0;
    fl   = 3'b000;
    if (run) begin
      if (red) begin
        pc = 1'b1;
        fl = (fd[k] == 1) ? 3'b001 : (fd[k] == 2) ? 3'b011 : 3'b111;
      end else if (stl) fl = 3'b010;
      else pc = 1'b1;
    end
    mask = (32'd1 << cw[k]) - 1;
    sc = PERF ? 16'(m_stall[k] & mask) : 16'd0;
    fc = PERF ? 16'(m_flush[k] & mask) : 16'd0;
    return {pc, pc, fl[0], fl[1], fl[2], pick(s.ex_rs, s, v), pick(s.ex_rt, s, v), v, sc, fc};
  endfunction

  task automatic model_step(input int k, input stim_t s);
    logic [W-1:0] o;
    logic [3:0]   v;
    logic         h, r, stl;
    if (!arst_n || !s.en) return;
    o   = model_out(k, s);
    v   = m_valid[k];
    h   = hz_of(k, s);
    r   = s.redirect && v[2];
    stl = (m_left[k] > 0) || h;
    m_valid[k] = {v[2], o[40] ? 1'b0 : v[1], o[41] ? 1'b0 : v[0], o[42] ? 1'b0 : (o[43] ? 1'b1 : v[0])};
    if (r)                 m_left[k] = 0;
    else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
    else if (h)            m_left[k] = luc[k] - 1;
    if (!r && stl) m_stall[k]++;
    if (r)         m_flush[k]++;
  endtask

  // driver
  task automatic apply(input stim_t s);
    bus1.enable = s.en;                 bus3.enable = s.en;
    bus1.id_rs = s.id_rs;               bus3.id_rs = s.id_rs;
    bus1.id_rt = s.id_rt;               bus3.id_rt = s.id_rt;
    bus1.id_uses_rt = s.id_uses_rt;     bus3.id_uses_rt = s.id_uses_rt;
    bus1.ex_rs = s.ex_rs;               bus3.ex_rs = s.ex_rs;
    bus1.ex_rt = s.ex_rt;               bus3.ex_rt = s.ex_rt;
    bus1.ex_mem_read = s.ex_mem_read;   bus3.ex_mem_read = s.ex_mem_read;
    bus1.ex_reg_write = s.ex_reg_write; bus3.ex_reg_write = s.ex_reg_write;
    bus1.ex_waddr = s.ex_waddr;         bus3.ex_waddr = s.ex_waddr;
    bus1.mem_reg_write = s.mem_reg_write; bus3.mem_reg_write = s.mem_reg_write;
    bus1.mem_waddr = s.mem_waddr;       bus3.mem_waddr = s.mem_waddr;
    bus1.wb_reg_write = s.wb_reg_write; bus3.wb_reg_write = s.wb_reg_write;
    bus1.wb_waddr = s.wb_waddr;         bus3.wb_waddr = s.wb_waddr;
    bus1.redirect = s.redirect;         bus3.redirect = s.redirect;
  endtask

  task automatic cycle(input stim_t s);
    apply(s);
    exp_q1.push_back(model_out(0, s));
    exp_q3.push_back(model_out(1, s));
    @(negedge clk);
    @(posedge clk);
    model_step(0, s);
    model_step(1, s);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.en            = ($urandom_range(0, 9) != 0);
    s.id_rs         = AW'($urandom_range(0, 3));
    s.id_rt         = AW'($urandom_range(0, 3));
    s.id_uses_rt    = 1'($urandom_range(0, 1));
    s.ex_rs         = AW'($urandom_range(0, 3));
    s.ex_rt         = AW'($urandom_range(0, 3));
    s.ex_mem_read   = ($urandom_range(0, 2) == 0);
    s.ex_reg_write  = ($urandom_range(0, 3) != 0);
    s.ex_waddr      = AW'($urandom_range(0, 3));
    s.mem_reg_write = 1'($urandom_range(0, 1));
    s.mem_waddr     = AW'($urandom_range(0, 3));
    s.wb_reg_write  = 1'($urandom_range(0, 1));
    s.wb_waddr      = AW'($urandom_range(0, 3));
    s.redirect      = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // scoreboard
  function automatic logic [W-1:0] obs1();
    return {bus1.pc_en, bus1.if_id_en, bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_flush,
            bus1.fwd_a_sel, bus1.fwd_b_sel, bus1.stage_valid, bus1.stall_cnt, bus1.flush_cnt};
  endfunction

  function automatic logic [W-1:0] obs3();
    return {bus3.pc_en, bus3.if_id_en, bus3.if_id_flush, bus3.id_ex_flush, bus3.ex_mem_flush,
            bus3.fwd_a_sel, bus3.fwd_b_sel, bus3.stage_valid, 12'd0, bus3.stall_cnt,
            12'd0, bus3.flush_cnt};
  endfunction

  task automatic compare(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    check({tag, "_ctl"}, 32'(o[44:32]), 32'(e[44:32]));
    check({tag, "_stall_cnt"}, 32'(o[31:16]), 32'(e[31:16]));
    check({tag, "_flush_cnt"}, 32'(o[15:0]), 32'(e[15:0]));
  endtask

  always @(negedge clk) begin
    if (exp_q1.size() != 0) compare("d1", obs1(), exp_q1.pop_front());
    if (exp_q3.size() != 0) compare("d3", obs3(), exp_q3.pop_front());
  end

  initial begin
    stim_t idle, s;
    idle    = '0;
    idle.en = 1'b1;
    model_reset();
    apply(idle);
    @(posedge clk); #1;
    repeat (2) cycle(idle);
    arst_n = 1'b1;

    // load-use: lw $2 in EX, add $3,$2,$4 in ID
    repeat (5) cycle(idle);
    s = idle; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_waddr = 5'd2;
    s.id_rs = 5'd2; s.id_rt = 5'd4; s.id_uses_rt = 1'b1;
    cycle(s);
    check("lu1_stall_cnt", 32'(bus1.stall_cnt), PERF ? 32'd1 : 32'd0);
    s.ex_mem_read = 1'b0; s.ex_reg_write = 1'b0;
    cycle(s);
    s = idle; s.ex_rs = 5'd2; s.ex_rt = 5'd4; s.wb_reg_write = 1'b1; s.wb_waddr = 5'd2;
    apply(s); #1;
    check("lu1_fwd_a_wb", 32'(bus1.fwd_a_sel), 32'(FWD_WB));
    cycle(s);
    check("lu3_stall_cnt", 32'(bus3.stall_cnt), PERF ? 32'd3 : 32'd0);
    check("lu3_back_to_run", 32'(bus3.state), 32'(RUN));

    // redirect with full pipe
    repeat (4) cycle(idle);
    s = idle; s.redirect = 1'b1;
    cycle(s);
    check("redir_valid_000", 32'(bus1.stage_valid[2:0]), 32'd0);
    check("redir_flush_cnt", 32'(bus1.flush_cnt), PERF ? 32'd1 : 32'd0);
    cycle(idle);
    check("redir_valid_001", 32'(bus1.stage_valid[2:0]), 32'd1);

    // redirect arriving while u_dut3 is in STALL
    repeat (4) cycle(idle);
    s = idle; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_waddr = 5'd3; s.id_rs = 5'd3;
    cycle(s);
    check("stall_entered", 32'(bus3.state), 32'(STALL));
    s = idle; s.redirect = 1'b1;
    cycle(s);
    check("stall_redir_run", 32'(bus3.state), 32'(RUN));
    apply(idle); #1;
    check("stall_redir_pc_en", 32'(bus3.pc_en), 32'd1);
    cycle(idle);

    // forwarding priority and register 0
    repeat (4) cycle(idle);
    s = idle; s.ex_rs = 5'd5; s.mem_reg_write = 1'b1; s.mem_waddr = 5'd5;
    s.wb_reg_write = 1'b1; s.wb_waddr = 5'd5;
    apply(s); #1;
    check("fwd_mem_prio", 32'(bus1.fwd_a_sel), 32'(FWD_MEM));
    cycle(s);
    s.mem_waddr = 5'd0; s.wb_waddr = 5'd0;
    apply(s); #1;
    check("fwd_waddr0", 32'(bus1.fwd_a_sel), 32'(FWD_RF));
    cycle(s);
    s.ex_rs = 5'd0;
    cycle(s);

    // async reset pulsed mid-STALL
    repeat (4) cycle(idle);
    s = idle; s.ex_mem_read = 1'b1; s.ex_reg_write = 1'b1; s.ex_waddr = 5'd1; s.id_rs = 5'd1;
    cycle(s);
    arst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", 32'(bus3.state), 32'(RUN));
    check("rst_valid", 32'(bus3.stage_valid), 32'd0);
    check("rst_stall_cnt", 32'(bus3.stall_cnt), 32'd0);
    cycle(idle);
    arst_n = 1'b1;

    // enable low with busy inputs: everything must hold
    repeat (6) cycle(idle);
    for (int i = 0; i < 5; i++) begin
      s = rand_stim(); s.en = 1'b0; s.redirect = 1'b1;
      cycle(s);
    end

    // random traffic with one reset pulse in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        arst_n = 1'b0;
        model_reset();
        cycle(idle);
        arst_n = 1'b1;
      end
      cycle(rand_stim());
    end

    @(negedge clk); #1;
    check("q1_drained", 32'(exp_q1.size()), 32'd0);
    check("q3_drained", 32'(exp_q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline-control block for the 5-stage MIPS-style core (IF, ID, EX, MEM, WB).
- Adds what the current pipeline lacks: per-stage valid tracking, load-use stall, flush on taken branch/jump resolved at EX_MEM, and EX-stage operand forwarding selects.
- Drives the enables and flushes of the reg_arstn_en pipeline registers and the PC enable.
- Parametrised in register-address width, load-use stall length, flush depth and counter width.

Parameters:
- ADDR_W, 5, register-file address width.
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- FLUSH_DEPTH, 3, younger stage registers squashed on redirect (IF_ID, ID_EX, EX_MEM in that order); legal range 1..3.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  global run enable; low freezes the pipeline
- id_rs  in  ADDR_W  rs field of instruction in ID (IF_ID)
- id_rt  in  ADDR_W  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, branch, store)
- ex_rs  in  ADDR_W  rs of instruction in EX (ID_EX)
- ex_rt  in  ADDR_W  rt of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes the register file
- ex_waddr  in  ADDR_W  EX destination register
- mem_reg_write  in  1  EX_MEM reg_write
- mem_waddr  in  ADDR_W  EX_MEM destination register
- wb_reg_write  in  1  MEM_WB reg_write
- wb_waddr  in  ADDR_W  MEM_WB destination register
- redirect  in  1  taken branch or jump at EX_MEM
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF_ID register enable
- if_id_flush  out  1  load bubble into IF_ID
- id_ex_flush  out  1  load bubble into ID_EX
- ex_mem_flush  out  1  load bubble into EX_MEM
- fwd_a_sel  out  2  ALU operand A source: 00 regfile, 01 EX_MEM alu_out, 10 MEM_WB wdata
- fwd_b_sel  out  2  ALU operand B source, same encoding
- stage_valid  out  4  valid bits for IF_ID, ID_EX, EX_MEM, MEM_WB (bits 0..3)
- stall_cnt  out  CNT_W  cycles spent stalled
- flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset (async, arst_n low): state RUN, stage_valid = 0, stall counter = 0, stall_cnt = 0, flush_cnt = 0. While in reset, pc_en = 0 and if_id_en = 0.
- FSM states:
  - RUN: normal operation.
  - STALL: remaining bubbles tracked by an internal down-counter.
- Hazard condition `hz`: asserted when all of the following hold:
  - stage_valid[0], ex_mem_read, ex_reg_write and stage_valid[1] are all 1;
  - ex_waddr != 0;
  - ex_waddr == id_rs, or (id_uses_rt and ex_waddr == id_rt).
- RUN, hz = 1, no redirect:
  - Same cycle: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - If LOAD_USE_CYCLES > 1: go to STALL with counter = LOAD_USE_CYCLES-2; otherwise remain in RUN.
- STALL: pc_en = 0, if_id_en = 0, id_ex_flush = 1. Counter decrements each enabled cycle; return to RUN when it reads 0.
- Redirect handling:
  - redirect is qualified by stage_valid[2].
  - When qualified: assert the first FLUSH_DEPTH of {if_id_flush, id_ex_flush, ex_mem_flush}, and hold pc_en = 1 so the PC takes the branch/jump target.
  - Redirect has priority over hz and over STALL: the FSM returns to RUN and the counter clears.
- stage_valid update on each enabled edge:
  - valid[i+1] <= valid[i], with bit 0 <= 1 (fetch is always valid).
  - A flushed register loads 0.
  - A stalled IF_ID holds its value; ID_EX loads 0 on a bubble.
- Forwarding (combinational, from EX inputs):
  - A = 01 if mem_reg_write, stage_valid[2], mem_waddr != 0 and mem_waddr == ex_rs.
  - Otherwise A = 10 if the same condition holds for the WB stage (wb_reg_write, stage_valid[3], wb_waddr != 0, wb_waddr == ex_rs).
  - Otherwise A = 00. B is identical using ex_rt.
  - EX_MEM has priority over MEM_WB.
  - Register 0 is never forwarded.
- enable = 0:
  - pc_en, if_id_en = 0; all flushes = 0.
  - FSM, valid bits and counters hold.
  - Forward selects still computed.
- Counters: stall_cnt +1 on each enabled cycle with pc_en = 0 caused by hz or STALL; flush_cnt +1 per qualified redirect. Both wrap modulo 2^CNT_W.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the fwd-select encoding constants (FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10);
  - the FSM state typedef (RUN, STALL);
  - stage index constants.
- One sub-module: fwd_sel_unit. It is purely combinational, produces one 2-bit select, and is instantiated twice (operands A and B).

Test Plan:
- lw $2 in EX, add $3,$2,$4 in ID, LOAD_USE_CYCLES = 1 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1; then fwd_a_sel = 10 when the add is in EX; stall_cnt = 1.
- LOAD_USE_CYCLES = 3, same hazard -> pc_en low for exactly 3 cycles; stall_cnt = 3.
- Redirect = 1 with stage_valid[2] = 1, FLUSH_DEPTH = 3 -> all three flushes high for 1 cycle; stage_valid[2:0] = 000 after the edge, then 001; flush_cnt = 1.
- Redirect arriving during STALL -> flushes asserted, FSM returns to RUN the next cycle, pc_en = 1.
- Writes to $5 in both EX_MEM and MEM_WB, with ex_rs = 5 -> fwd_a_sel = 01. With waddr = 0 in both -> fwd_a_sel = 00.
- arst_n pulsed low mid-STALL -> state RUN, stage_valid = 0, counters = 0. enable = 0 for 5 cycles -> valid bits and counters unchanged.
